mod107_residue_accumulator: RTL

Serial accumulator that sits directly downstream of the per-chunk mod-107 LUT stage. It takes one 7-bit residue per accepted beat, each already equal to chunk·2^(6k) mod 107 for chunk index k, and sums them modulo 107 into the final residue of a wide operand of up to 300 bits (50 six-bit chunks). It drives the chunk index upstream so the LUT mux can select the matching table, and presents the result through a valid/ready handshake.

---
 rtl/mod107_residue_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mod107_residue_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mod107_residue_accumulator                                 |
// | Description : Serial mod-107 accumulator for per-chunk LUT residues.     |
// |               Sums one residue per accepted beat with a single           |
// |               conditional subtract. It drives the chunk index upstream   |
// |               and returns the result over a valid/ready handshake.       |
// |               Optional macro MOD107_RANGE_CHECK_EN enables a sticky      |
// |               err flag for input residues >= 107.                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mod107_residue_accumulator #(
  parameter int MOD      = 107,
  parameter int RW       = 7,
  parameter int N_CHUNKS = 50,
  parameter int IDX_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [RW-1:0]    in_res_i,
  input  logic             in_last_i,
  output logic [IDX_W-1:0] in_idx_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RW-1:0]    out_res_o,
  output logic [IDX_W-1:0] out_count_o,
  output logic             err_o
);

  localparam logic [RW:0]    C_MOD      = (RW+1)'(MOD);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_CHUNKS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [RW-1:0]    acc_q;
  logic [IDX_W-1:0] idx_q;
  logic             out_valid_q;
  logic [RW-1:0]    out_res_q;
  logic [IDX_W-1:0] out_count_q;

  logic [RW:0]      sum_w;
  logic [RW-1:0]    acc_d;
  logic             accept_w;
  logic             term_w;
  logic             handshake_w;

  // Reduce the 8-bit sum with exactly one conditional subtract; out-of-range
  // inputs are not clamped, so the stored value may exceed MOD-1.
  always_comb begin
    sum_w = {1'b0, acc_q} + {1'b0, in_res_i};
    if (sum_w >= C_MOD) begin
      acc_d = RW'(sum_w - C_MOD);
    end else begin
      acc_d = sum_w[RW-1:0];
    end
  end

  assign accept_w    = in_valid_i && (state_q == ACC);
  assign term_w      = in_last_i || (idx_q == C_LAST_IDX);
  assign handshake_w = (state_q == HOLD) && out_ready_i;

  // Main control: accumulate in ACC, present and hold the result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept_w) begin
            idx_q <= idx_q + C_IDX_ONE;
            if (term_w) begin
              out_res_q   <= acc_d;
              out_count_q <= idx_q + C_IDX_ONE;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            state_q     <= ACC;
          end
        end
        default: begin
          state_q <= ACC;
        end
      endcase
    end
  end

`ifdef MOD107_RANGE_CHECK_EN
  logic err_q;
  logic bad_w;

  assign bad_w = ({1'b0, in_res_i} >= C_MOD);

  // Sticky range flag for the current operand, cleared with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (handshake_w) begin
      err_q <= 1'b0;
    end else if (accept_w && bad_w) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_hs_w;
  assign unused_hs_w = handshake_w;
  assign err_o       = 1'b0;
`endif

  assign in_ready_o  = (state_q == ACC);
  assign in_idx_o    = idx_q;
  assign out_valid_o = out_valid_q;
  assign out_res_o   = out_res_q;
  assign out_count_o = out_count_q;

endmodule
`default_nettype wire
